// File: rtl/instr_prefetch.sv
// Purpose : instruction prefetcher; walks a parallel ROM image from address 0 (start) or
//           jump_addr (flush) and buffers fetched words in a DEPTH-entry FIFO for a consumer.
// Latency : first instruction valid one cycle after the start/flush edge; one push per cycle.
// Backpr. : fetching pauses while the queue is full and out_ready is low; the head holds steady.
// Option  : define INSTR_PREFETCH_STOP_DETECT_EN to end fetching on a word whose opcode
//           equals STOP_OPCODE (that word is still queued).
// Ports   : clk, rst_n (async, active-low); rom_data (word k at [20k+19:20k]);
//           start (pulse, fetch from 0); flush + jump_addr (discard queue, refetch from jump_addr);
//           out_valid/out_ready/out_instr/out_pc (head of queue); fetch_pc (next fetch address);
//           done (fetching ended and queue drained).
// ROM_WORDS must be 1..15 so that fetch_pc can hold ROM_WORDS once the image is exhausted.
module instr_prefetch #(
  parameter int         ROM_WORDS   = 8,
  parameter int         DEPTH       = 4,
  parameter logic [3:0] STOP_OPCODE = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [20*ROM_WORDS-1:0] rom_data,
  input  logic                    start,
  input  logic                    flush,
  input  logic [3:0]              jump_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [19:0]             out_instr,
  output logic [3:0]              out_pc,
  output logic [3:0]              fetch_pc,
  output logic                    done
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [4:0]       ROM_LIMIT = 5'(ROM_WORDS);
  localparam logic [3:0]       LAST_PC   = 4'(ROM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [19:0]      r_mem_instr [DEPTH];
  logic [3:0]       r_mem_pc    [DEPTH];

  logic [19:0]      w_fetch_word;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_last_word;
  logic             w_stop_hit;
  logic             w_jump_oob;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ROM word at fetch_pc; addresses outside the image read as zero.
  always_comb begin
    w_fetch_word = '0;
    for (int k = 0; k < ROM_WORDS; k++) begin
      if (r_fetch_pc == 4'(k)) w_fetch_word = rom_data[20*k +: 20];
    end
  end

  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = out_valid & out_ready;
  assign w_last_word = (r_fetch_pc == LAST_PC);
  assign w_jump_oob  = ({1'b0, jump_addr} >= ROM_LIMIT);

`ifdef INSTR_PREFETCH_STOP_DETECT_EN
  assign w_stop_hit = (w_fetch_word[19:16] == STOP_OPCODE);
`else
  assign w_stop_hit = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  // Flush wins over everything, from any state. Start always targets address 0,
  // which is inside the image for any legal ROM_WORDS, so it always lands in RUN.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = w_jump_oob ? S_END : S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_RUN;
        S_RUN:   if (w_push && (w_last_word || w_stop_hit)) w_next_state = S_END;
        S_END:   w_next_state = S_END;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // A full queue may still accept a push in the same cycle its head is taken.
  always_comb begin
    w_push = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_RUN:   w_push = !flush && (!w_full || w_pop);
      S_END:   done   = (r_count == '0);
      default: ;
    endcase
  end

  // ---------------- fetch address ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_fetch_pc <= 4'd0;
    else if (flush)                      r_fetch_pc <= jump_addr;
    else if (r_state == S_IDLE && start) r_fetch_pc <= 4'd0;
    else if (w_push)                     r_fetch_pc <= r_fetch_pc + 4'd1;
  end

  // ---------------- queue control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // The head shown this cycle is considered consumed if taken; everything is dropped.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the read side is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= w_fetch_word;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 20'd0;
  assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]    : 4'd0;
  assign fetch_pc  = r_fetch_pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch (ROM_WORDS=8, DEPTH=4): reset values, streaming,
// backpressure, in-range and out-of-range flush, stop-opcode handling and mid-run reset.
module tb_instr_prefetch;

  logic         clk;
  logic         rst_n;
  logic [159:0] rom_data;
  logic         start;
  logic         flush;
  logic [3:0]   jump_addr;
  logic         out_valid;
  logic         out_ready;
  logic [19:0]  out_instr;
  logic [3:0]   out_pc;
  logic [3:0]   fetch_pc;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  instr_prefetch #(.ROM_WORDS(8), .DEPTH(4), .STOP_OPCODE(4'hF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_data  (rom_data),
    .start     (start),
    .flush     (flush),
    .jump_addr (jump_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .fetch_pc  (fetch_pc),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int k = 0; k < 8; k++) rom_data[20*k +: 20] = 20'(32'h10000 + k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; jump_addr = 4'd0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    load_program();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; jump_addr = 4'd0; out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_vec++; if (out_instr !== 20'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    n_vec++; if (out_pc !== 4'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", out_pc); end
    n_vec++; if (fetch_pc !== 4'd0) begin n_err++; $display("FAIL reset_fetch_pc got %0d exp 0", fetch_pc); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_fetch got %b exp 0", out_valid); end
  endtask

  // Full-speed drain: one instruction per cycle, a stray start mid-run is ignored.
  task automatic test_stream();
    do_reset();
    load_program();
    out_ready = 1'b1;
    pulse_start();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_latency valid=%b exp 0", out_valid); end
    n_vec++; if (fetch_pc !== 4'd0) begin n_err++; $display("FAIL stream_start_pc got %0d exp 0", fetch_pc); end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 4'(k) || out_instr !== 20'(32'h10000 + k)) begin
        n_err++;
        $display("FAIL stream_word%0d got v=%b pc=%0d instr=%h exp v=1 pc=%0d instr=%h",
                 k, out_valid, out_pc, out_instr, k, 20'(32'h10000 + k));
      end
    end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL stream_done_early got %b exp 0", done); end
    tick();
    n_vec++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL stream_done got done=%b v=%b exp 1/0", done, out_valid); end
    n_vec++; if (fetch_pc !== 4'd8) begin n_err++; $display("FAIL stream_fetch_pc got %0d exp 8", fetch_pc); end
  endtask

  // Stalled consumer fills the queue to DEPTH; then flush to 6 from a queue holding 2..5.
  task automatic test_stall_and_flush();
    do_reset();
    load_program();
    out_ready = 1'b0;
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++;
      if (fetch_pc !== 4'((k < 4) ? k : 4)) begin
        n_err++; $display("FAIL stall_fetch_pc cyc%0d got %0d exp %0d", k, fetch_pc, (k < 4) ? k : 4);
      end
    end
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd0 || out_instr !== 20'h10000) begin
      n_err++; $display("FAIL stall_head got v=%b pc=%0d instr=%h exp 1/0/10000", out_valid, out_pc, out_instr);
    end
    // Pop two heads while the full queue keeps refilling: queue becomes 2..5, fetch_pc 6.
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    n_vec++; if (out_pc !== 4'd2 || fetch_pc !== 4'd6) begin
      n_err++; $display("FAIL full_pop_push got pc=%0d fetch=%0d exp 2/6", out_pc, fetch_pc);
    end
    flush = 1'b1; jump_addr = 4'd6;
    tick();
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || fetch_pc !== 4'd6) begin
      n_err++; $display("FAIL flush_clears got v=%b fetch=%0d exp 0/6", out_valid, fetch_pc);
    end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd6) begin n_err++; $display("FAIL flush_first got v=%b pc=%0d exp 1/6", out_valid, out_pc); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd7) begin n_err++; $display("FAIL flush_second got v=%b pc=%0d exp 1/7", out_valid, out_pc); end
    tick();
    n_vec++; if (done !== 1'b1 || out_valid !== 1'b0 || fetch_pc !== 4'd8) begin
      n_err++; $display("FAIL flush_done got done=%b v=%b fetch=%0d exp 1/0/8", done, out_valid, fetch_pc);
    end
  endtask

  // Out-of-range flush goes straight to END; END ignores start but leaves on a flush.
  task automatic test_flush_oob();
    do_reset();
    load_program();
    out_ready = 1'b0;
    pulse_start();
    tick(); tick(); tick();
    flush = 1'b1; jump_addr = 4'd9;
    tick();
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || done !== 1'b1 || fetch_pc !== 4'd9) begin
      n_err++; $display("FAIL oob_end got v=%b done=%b fetch=%0d exp 0/1/9", out_valid, done, fetch_pc);
    end
    pulse_start();
    tick();
    n_vec++; if (out_valid !== 1'b0 || fetch_pc !== 4'd9) begin
      n_err++; $display("FAIL end_ignores_start got v=%b fetch=%0d exp 0/9", out_valid, fetch_pc);
    end
    flush = 1'b1; jump_addr = 4'd7;
    tick();
    flush = 1'b0;
    n_vec++; if (done !== 1'b0 || fetch_pc !== 4'd7) begin n_err++; $display("FAIL end_flush_run got done=%b fetch=%0d exp 0/7", done, fetch_pc); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd7 || fetch_pc !== 4'd8) begin
      n_err++; $display("FAIL end_flush_word got v=%b pc=%0d fetch=%0d exp 1/7/8", out_valid, out_pc, fetch_pc);
    end
    out_ready = 1'b1;
    tick();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL end_flush_done got %b exp 1", done); end
  endtask

  // Word 3 carries the stop opcode; only the stop-detect build ends fetching there.
  task automatic test_stop_opcode();
    int n_out;
    int exp_n;
    bit seen_done;
`ifdef INSTR_PREFETCH_STOP_DETECT_EN
    exp_n = 4;
`else
    exp_n = 8;
`endif
    do_reset();
    load_program();
    rom_data[60 +: 20] = 20'hF_0000;
    out_ready = 1'b1;
    n_out = 0;
    seen_done = 1'b0;
    pulse_start();
    for (int c = 0; c < 20 && !seen_done; c++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_pc !== 4'(n_out)) begin n_err++; $display("FAIL stop_seq got pc=%0d exp %0d", out_pc, n_out); end
        n_out++;
      end
    end
    n_vec++; if (!seen_done) begin n_err++; $display("FAIL stop_timeout got done=%b exp 1", done); end
    n_vec++; if (n_out != exp_n) begin n_err++; $display("FAIL stop_count got %0d exp %0d", n_out, exp_n); end
    n_vec++; if (fetch_pc !== 4'(exp_n)) begin n_err++; $display("FAIL stop_fetch_pc got %0d exp %0d", fetch_pc, exp_n); end
  endtask

  // Reset with three entries queued drops them at once; nothing resumes without a start.
  task automatic test_reset_mid();
    do_reset();
    load_program();
    out_ready = 1'b0;
    pulse_start();
    tick(); tick(); tick();
    n_vec++; if (out_valid !== 1'b1 || fetch_pc !== 4'd3) begin
      n_err++; $display("FAIL mid_prefill got v=%b fetch=%0d exp 1/3", out_valid, fetch_pc);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || fetch_pc !== 4'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_async got v=%b fetch=%0d done=%b exp 0/0/0", out_valid, fetch_pc, done);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (out_valid !== 1'b0 || fetch_pc !== 4'd0) begin
      n_err++; $display("FAIL mid_wait_start got v=%b fetch=%0d exp 0/0", out_valid, fetch_pc);
    end
    pulse_start();
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
      n_err++; $display("FAIL mid_restart got v=%b pc=%0d exp 1/0", out_valid, out_pc);
    end
  endtask

  initial begin
    rom_data = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; jump_addr = 4'd0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_and_flush();
    test_flush_oob();
    test_stop_opcode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter ROM_WORDS, default 8, SHALL set the number of 20-bit instruction words in the program image.
REQ-002 Parameter DEPTH, default 4, SHALL set the prefetch queue depth in instructions (2..8).
REQ-003 Parameter STOP_OPCODE, default 4'hF, SHALL set the opcode value treated as program end.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rom_data  input  20*ROM_WORDS  program image; word k SHALL be bits [20k+19:20k].
REQ-007 start  input  1  one-cycle pulse; begins fetching at address 0.
REQ-008 flush  input  1  redirect; discards the queue and restarts fetching at jump_addr.
REQ-009 jump_addr  input  4  restart address, used only when flush=1.
REQ-010 out_valid  output  1  out_instr/out_pc hold a valid queued instruction.
REQ-011 out_ready  input  1  consumer accepts the head; transfer when out_valid & out_ready.
REQ-012 out_instr  output  20  head instruction; opcode [19:16], operand1 [15:8], operand2 [7:0].
REQ-013 out_pc  output  4  ROM address of out_instr.
REQ-014 fetch_pc  output  4  next ROM address to fetch (debug).
REQ-015 done  output  1  high when state is END and the queue is empty.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, END; IDLE->RUN on start or flush; RUN->END on the end conditions of REQ-021/REQ-022; END->RUN on flush; END ignores start.
REQ-017 In RUN, each cycle the queue is not full, or is full but a transfer occurs that cycle, the block SHALL push rom_data word fetch_pc with its address and increment fetch_pc by 1.
REQ-018 The queue SHALL be FIFO; out_instr/out_pc SHALL present the oldest entry combinationally from registered storage; out_valid = (count != 0).
REQ-019 start sampled at edge N SHALL set fetch_pc=0 and state RUN at N; first push at N+1, so out_valid is first high after edge N+1.
REQ-020 Pushes SHALL NOT occur in IDLE or END; pops SHALL occur in any state when out_valid & out_ready.
REQ-021 After pushing address ROM_WORDS-1 the state SHALL become END; fetch_pc SHALL equal ROM_WORDS and SHALL NOT wrap.
REQ-022 A flush or start with address >= ROM_WORDS SHALL enter END directly with no push.
REQ-023 flush SHALL take priority over push, pop and start: at that edge count=0, fetch_pc=jump_addr, state RUN (or END per REQ-022); the head visible in the flush cycle counts as consumed if out_ready=1, and nothing else is retained.
REQ-024 start while in RUN SHALL be ignored.
REQ-025 count SHALL never exceed DEPTH nor underflow; out_valid and out_instr SHALL stay stable while out_valid & ~out_ready.

Reset
REQ-026 While rst_n=0: state IDLE, count 0, fetch_pc 0, out_valid 0, out_instr 0, out_pc 0, done 0; queue storage contents are don't-care.
REQ-027 Reset asserted mid-operation SHALL discard all queued instructions immediately; after release the block SHALL wait for start.

Configuration
REQ-028 With macro INSTR_PREFETCH_STOP_DETECT_EN defined, pushing a word whose [19:16]=STOP_OPCODE SHALL move RUN->END at that edge (the STOP word itself is queued); undefined, opcodes SHALL NOT affect fetching and only REQ-021/REQ-022 end fetching.

Verification
REQ-029 Reset, word k = 20'h1_0000+k, start pulse, out_ready=1 -> out_pc 0..7 in consecutive cycles from start+2, then done=1, fetch_pc=8.
REQ-030 Same program, out_ready=0 -> exactly DEPTH=4 pushes, out_valid held with out_pc=0, fetch_pc=4, no further change.
REQ-031 Queue holding addresses 2..5, flush with jump_addr=6 -> next out_pc is 6 one cycle after flush edge, then 7, then done.
REQ-032 flush with jump_addr=9 -> END immediately, out_valid=0, done=1 next cycle.
REQ-033 STOP_DETECT_EN defined, word 3 = 20'hF_0000 -> out_pc 0..3 delivered, fetch_pc=4, done after word 3 consumed; undefined -> addresses 0..7 delivered.
REQ-034 rst_n pulled low with 3 entries queued -> out_valid=0 during reset; after release no output until a new start.
